// File: rtl/clock_pkg.sv
// Shared constants and types for the 24-hour BCD clock controller.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_SET_HOUR = 2'b01,
    ST_SET_MIN  = 2'b10,
    ST_INVALID  = 2'b11
  } state_e;

  localparam int unsigned HOUR_MAX_T = 2;
  localparam int unsigned HOUR_MAX_O = 3;
  localparam int unsigned MIN_MAX_T  = 5;
  localparam int unsigned MIN_MAX_O  = 9;
  localparam int unsigned SEC_MAX_T  = 5;
  localparam int unsigned SEC_MAX_O  = 9;

  localparam int unsigned HOUR_T_W = 2;
  localparam int unsigned MIN_T_W  = 3;
  localparam int unsigned SEC_T_W  = 3;
  localparam int unsigned ONES_W   = 4;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps to 00 after reaching (MAX_T, MAX_O).
module bcd_mod_counter #(
  parameter int unsigned TENS_W = 3,
  parameter int unsigned MAX_T  = 5,
  parameter int unsigned MAX_O  = 9
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              i_inc,
  input  logic              i_clr,
  output logic [TENS_W-1:0] o_tens,
  output logic [3:0]        o_ones,
  output logic              o_wrap_c
);

  logic [TENS_W-1:0] r_tens;
  logic [3:0]        r_ones;
  logic              w_at_max;

  // The wrap is decided on the full digit pair, so 23 wraps but 13 does not.
  assign w_at_max = (r_tens == TENS_W'(MAX_T)) && (r_ones == 4'(MAX_O));
  assign o_wrap_c = i_inc & w_at_max;

  // Digit update: clear beats increment; ones roll 9 -> 0 into the tens.
  always_ff @(posedge clk_in) begin
    if (rst || i_clr) begin
      r_tens <= '0;
      r_ones <= '0;
    end else if (i_inc) begin
      if (w_at_max) begin
        r_tens <= '0;
        r_ones <= '0;
      end else if (r_ones == 4'd9) begin
        r_tens <= r_tens + TENS_W'(1);
        r_ones <= '0;
      end else begin
        r_ones <= r_ones + 4'd1;
      end
    end
  end

  assign o_tens = r_tens;
  assign o_ones = r_ones;

endmodule

// File: rtl/time_set_ctrl.sv
// Mode FSM, button edge detection, blink and BCD time counters for the lab clock.
module time_set_ctrl
  import clock_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_up,
  output logic [1:0] hour_t,
  output logic [3:0] hour_o,
  output logic [2:0] min_t,
  output logic [3:0] min_o,
  output logic [2:0] sec_t,
  output logic [3:0] sec_o,
  output logic [1:0] mode,
  output logic       blank_hour,
  output logic       blank_min
);

  state_e r_state;
  state_e w_state_nxt;
  logic   r_blink;
  logic   w_blink_nxt;
  logic   r_blank_hour;
  logic   r_blank_min;
  logic   r_btn_mode_q;
  logic   r_btn_up_q;

  logic   w_mode_press;
  logic   w_up_press;
  logic   w_run;
  logic   w_sec_inc;
  logic   w_sec_clr;
  logic   w_min_inc;
  logic   w_hour_inc;
  logic   w_sec_wrap;
  logic   w_min_wrap;
  logic   w_hour_wrap;

  // Previous-cycle button samples; reset loads the live level so a held button is not a press.
  always_ff @(posedge clk_in) begin
    r_btn_mode_q <= btn_mode;
    r_btn_up_q   <= btn_up;
  end

  assign w_mode_press = btn_mode & ~r_btn_mode_q;
  assign w_up_press   = btn_up & ~r_btn_up_q & ~w_mode_press;
  assign w_run        = (r_state == ST_RUN);

  // Counter controls: carries only ripple in RUN; SET increments never carry.
  assign w_sec_inc  = w_run & tick;
  assign w_sec_clr  = (r_state == ST_SET_MIN) & w_mode_press;
  assign w_min_inc  = (w_run & w_sec_wrap) | ((r_state == ST_SET_MIN) & w_up_press);
  assign w_hour_inc = (w_run & w_min_wrap) | ((r_state == ST_SET_HOUR) & w_up_press);

  // Next mode and blink; any mode change restarts blink from visible.
  always_comb begin
    w_state_nxt = r_state;
    w_blink_nxt = r_blink;
    if (r_state == ST_INVALID) begin
      w_state_nxt = ST_RUN;
      w_blink_nxt = 1'b0;
    end else if (w_mode_press) begin
      case (r_state)
        ST_RUN:      w_state_nxt = ST_SET_HOUR;
        ST_SET_HOUR: w_state_nxt = ST_SET_MIN;
        default:     w_state_nxt = ST_RUN;
      endcase
      w_blink_nxt = 1'b0;
    end else if (w_run) begin
      w_blink_nxt = 1'b0;
    end else if (tick) begin
      w_blink_nxt = ~r_blink;
    end
  end

  // Mode state register with registered blank flags.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_blink      <= 1'b0;
      r_blank_hour <= 1'b0;
      r_blank_min  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_blink      <= w_blink_nxt;
      r_blank_hour <= (w_state_nxt == ST_SET_HOUR) & w_blink_nxt;
      r_blank_min  <= (w_state_nxt == ST_SET_MIN) & w_blink_nxt;
    end
  end

  bcd_mod_counter #(
    .TENS_W (SEC_T_W),
    .MAX_T  (SEC_MAX_T),
    .MAX_O  (SEC_MAX_O)
  ) u_sec (
    .clk_in   (clk_in),
    .rst      (rst),
    .i_inc    (w_sec_inc),
    .i_clr    (w_sec_clr),
    .o_tens   (sec_t),
    .o_ones   (sec_o),
    .o_wrap_c (w_sec_wrap)
  );

  bcd_mod_counter #(
    .TENS_W (MIN_T_W),
    .MAX_T  (MIN_MAX_T),
    .MAX_O  (MIN_MAX_O)
  ) u_min (
    .clk_in   (clk_in),
    .rst      (rst),
    .i_inc    (w_min_inc),
    .i_clr    (1'b0),
    .o_tens   (min_t),
    .o_ones   (min_o),
    .o_wrap_c (w_min_wrap)
  );

  bcd_mod_counter #(
    .TENS_W (HOUR_T_W),
    .MAX_T  (HOUR_MAX_T),
    .MAX_O  (HOUR_MAX_O)
  ) u_hour (
    .clk_in   (clk_in),
    .rst      (rst),
    .i_inc    (w_hour_inc),
    .i_clr    (1'b0),
    .o_tens   (hour_t),
    .o_ones   (hour_o),
    .o_wrap_c (w_hour_wrap)
  );

  // Hour wrap has no consumer; the clock simply rolls over at midnight.
  logic w_unused;
  assign w_unused = w_hour_wrap;

  assign mode       = r_state;
  assign blank_hour = r_blank_hour;
  assign blank_min  = r_blank_min;

endmodule
